// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the register-file / compute sequencer.
// Holds the 2-bit state encoding (also driven out on current_state) and the
// default parameter values used by seq_state_control.
package seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RF_RW   = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_RF_W    = 2'd3
    } state_t;

    localparam int         DEF_CMD_W        = 3;
    localparam int         DEF_CNT_W        = 5;
    localparam int         DEF_LAT_RF_READ  = 4;
    localparam int         DEF_LAT_COMPUTE  = 8;
    localparam int         DEF_LAT_RF_WRITE = 4;
    localparam int         DEF_OPS_W        = 16;
    // Commands 5, 6 and 7 take the compute path by default.
    localparam logic [7:0] DEF_COMPUTE_MASK = 8'b1110_0000;

endpackage

// File: rtl/seq_lat_counter.sv
// Per-state latency counter for the sequencer.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   clr         force count to 0 (highest priority)
//   load        start a new state: count <= 1
//   en          advance count by one
//   lat         latency of the current state
//   at_lat      count has reached lat
module seq_lat_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] lat,
    output logic             at_lat
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    cnt <= '0;
        else if (clr)  cnt <= '0;
        else if (load) cnt <= CNT_W'(1);
        else if (en)   cnt <= cnt + CNT_W'(1);
    end

    assign at_lat = (cnt == lat);

endmodule

// File: rtl/seq_state_control.sv
// Multi-cycle sequencer: one command per valid/ready handshake, walked through
// RF_RW and, for commands flagged in COMPUTE_MASK, COMPUTE then RF_W.
// Supports hold (freeze), abort (cancel), a one-cycle done pulse and a
// wrapping completed-command counter.
// Ports:
//   clk, rst_n     clock / async active-low reset
//   cmd_valid      command offered;  cmd_ready  accept possible (IDLE)
//   command        command, captured into cmd_q on accept
//   hold, abort    freeze / cancel while busy (abort wins)
//   done           one-cycle completion pulse;  busy  state != IDLE
//   current_state  0 IDLE, 1 RF_RW, 2 COMPUTE, 3 RF_W
//   done_count     completed commands, modulo 2**OPS_W
module seq_state_control
    import seq_ctrl_pkg::*;
#(
    parameter int                        CMD_W        = DEF_CMD_W,
    parameter int                        CNT_W        = DEF_CNT_W,
    parameter int                        LAT_RF_READ  = DEF_LAT_RF_READ,
    parameter int                        LAT_COMPUTE  = DEF_LAT_COMPUTE,
    parameter int                        LAT_RF_WRITE = DEF_LAT_RF_WRITE,
    parameter logic [(2**CMD_W)-1:0]     COMPUTE_MASK = DEF_COMPUTE_MASK,
    parameter int                        OPS_W        = DEF_OPS_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CMD_W-1:0] command,
    input  logic             hold,
    input  logic             abort,
    output logic             done,
    output logic             busy,
    output logic [1:0]       current_state,
    output logic [CMD_W-1:0] cmd_q,
    output logic [OPS_W-1:0] done_count
);

    localparam int CNT_MAX = (2**CNT_W) - 1;

    if (LAT_RF_READ  < 1 || LAT_RF_READ  > CNT_MAX ||
        LAT_COMPUTE  < 1 || LAT_COMPUTE  > CNT_MAX ||
        LAT_RF_WRITE < 1 || LAT_RF_WRITE > CNT_MAX) begin : g_lat_check
        $error("seq_state_control: every LAT_* must be in 1..2**CNT_W-1");
    end

    state_t           state, state_nx;
    logic             cnt_clr, cnt_load, cnt_en, at_lat;
    logic             done_nx;
    logic             accept;
    logic [CNT_W-1:0] lat_sel;

    assign cmd_ready     = (state == ST_IDLE);
    assign busy          = (state != ST_IDLE);
    assign current_state = state;
    assign accept        = cmd_valid && (state == ST_IDLE);

    always_comb begin
        lat_sel = '0;
        case (state)
            ST_RF_RW:   lat_sel = CNT_W'(LAT_RF_READ);
            ST_COMPUTE: lat_sel = CNT_W'(LAT_COMPUTE);
            ST_RF_W:    lat_sel = CNT_W'(LAT_RF_WRITE);
            default:    lat_sel = '0;
        endcase
    end

    seq_lat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (cnt_clr),
        .load   (cnt_load),
        .en     (cnt_en),
        .lat    (lat_sel),
        .at_lat (at_lat)
    );

    always_comb begin
        state_nx = state;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        done_nx  = 1'b0;
        if (state == ST_IDLE) begin
            if (cmd_valid) begin
                state_nx = ST_RF_RW;
                cnt_load = 1'b1;
            end
        end else if (abort) begin
            state_nx = ST_IDLE;
            cnt_clr  = 1'b1;
        end else if (!hold) begin
            if (!at_lat) begin
                cnt_en = 1'b1;
            end else begin
                case (state)
                    ST_RF_RW: begin
                        if (COMPUTE_MASK[cmd_q]) begin
                            state_nx = ST_COMPUTE;
                            cnt_load = 1'b1;
                        end else begin
                            state_nx = ST_IDLE;
                            cnt_clr  = 1'b1;
                            done_nx  = 1'b1;
                        end
                    end
                    ST_COMPUTE: begin
                        state_nx = ST_RF_W;
                        cnt_load = 1'b1;
                    end
                    default: begin
                        state_nx = ST_IDLE;
                        cnt_clr  = 1'b1;
                        done_nx  = 1'b1;
                    end
                endcase
            end
        end
    end

    // Completion lands us in IDLE with done high, so a command offered in
    // that same cycle is accepted without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cmd_q      <= '0;
            done       <= 1'b0;
            done_count <= '0;
        end else begin
            state <= state_nx;
            done  <= done_nx;
            if (accept)  cmd_q      <= command;
            if (done_nx) done_count <= done_count + OPS_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_state_control.sv
// Randomised scoreboard bench for seq_state_control (OPS_W=2 so the
// completion counter wraps often).
module tb_seq_state_control;

    localparam int LR   = 4;
    localparam int LC   = 8;
    localparam int LW   = 4;
    localparam int OPS  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       hold = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] command = '0;
    logic       cmd_ready, done, busy;
    logic [1:0] current_state;
    logic [2:0] cmd_q;
    logic [OPS-1:0] done_count;

    seq_state_control #(.OPS_W(OPS)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .command       (command),
        .hold          (hold),
        .abort         (abort),
        .done          (done),
        .busy          (busy),
        .current_state (current_state),
        .cmd_q         (cmd_q),
        .done_count    (done_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int dn;
        int dc;
        int cq;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   dones_seen = 0;

    // Reference model: a command is "busy" for a fixed number of advancing
    // edges; the visible phase follows from how many have elapsed.
    bit m_busy = 0;
    int m_el = 0;
    int m_tot = 0;
    int m_cnt = 0;
    int m_cq = 0;
    int m_done = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int exp_state();
        if (!m_busy)        return 0;
        if (m_el < LR)      return 1;
        if (m_el < LR + LC) return 2;
        return 3;
    endfunction

    task automatic push_exp();
        exp_t e;
        e.st = exp_state();
        e.dn = m_done;
        e.dc = m_cnt;
        e.cq = m_cq;
        exp_q.push_back(e);
    endtask

    // Called at negedge+1: drive, model the coming edge, return at negedge+1.
    task automatic step(input bit v, input int c, input bit h, input bit a);
        cmd_valid = v;
        command   = 3'(c);
        hold      = h;
        abort     = a;
        @(posedge clk);
        m_done = 0;
        if (m_busy) begin
            if (a) begin
                m_busy = 0;
            end else if (!h) begin
                m_el++;
                if (m_el == m_tot) begin
                    m_busy = 0;
                    m_done = 1;
                    m_cnt  = (m_cnt + 1) % (1 << OPS);
                end
            end
        end else if (v) begin
            m_busy = 1;
            m_el   = 0;
            m_cq   = c;
            m_tot  = (c inside {5, 6, 7}) ? LR + LC + LW : LR;
        end
        push_exp();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        hold      = 1'b0;
        abort     = 1'b0;
        #1;
        chk("reset_state", int'(current_state), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_ready", int'(cmd_ready), 1);
        chk("reset_count", int'(done_count), 0);
        m_busy = 0; m_el = 0; m_cnt = 0; m_cq = 0; m_done = 0;
        @(posedge clk);
        push_exp();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compares every cycle's outputs against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("state", int'(current_state), e.st);
                chk("done", int'(done), e.dn);
                chk("done_count", int'(done_count), e.dc);
                chk("cmd_q", int'(cmd_q), e.cq);
                chk("cmd_ready", int'(cmd_ready), (e.st == 0) ? 1 : 0);
                chk("busy", int'(busy), (e.st != 0) ? 1 : 0);
                if (done) dones_seen++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        #1;
        do_reset();

        // Async reset in the middle of COMPUTE (cnt=5).
        step(1, 7, 0, 0);
        repeat (8) step(0, 0, 0, 0);
        do_reset();

        // Non-compute command.
        step(1, 2, 0, 0);
        repeat (6) step(0, 0, 0, 0);

        // Compute command, full path.
        step(1, 7, 0, 0);
        repeat (18) step(0, 0, 0, 0);

        // Three hold cycles inside COMPUTE.
        step(1, 5, 0, 0);
        repeat (5) step(0, 0, 0, 0);
        repeat (3) step(0, 0, 1, 0);
        repeat (13) step(0, 0, 0, 0);

        // Abort with hold at RF_W cnt=2, cmd_valid offered while busy.
        step(1, 6, 0, 0);
        repeat (13) step(1, 3, 0, 0);
        step(1, 1, 1, 1);
        repeat (3) step(0, 0, 0, 0);

        // Back-to-back with cmd_valid held high; counter wraps.
        for (int i = 0; i < 60; i++) step(1, (i % 3 == 0) ? 7 : i % 5, 0, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0)
                do_reset();
            else
                step($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
                     $urandom_range(0, 4) == 0, $urandom_range(0, 39) == 0);
        end

        repeat (2) step(0, 0, 0, 0);
        chk("queue_drained", exp_q.size(), 0);
        chk("enough_completions", (dones_seen > 20) ? 1 : 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
